// File: rtl/operand_latch_adder_if.sv
// Operand/result bundle between the demux-side driver and operand_latch_adder.
// Carries the optional sub control when SUBTRACT_EN is defined.
interface operand_latch_adder_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] a_bus;
   logic [WIDTH-1:0] b_bus;
   logic             select;
   logic             btn_load;
   logic             clear;
`ifdef SUBTRACT_EN
   logic             sub;
`endif
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH:0]   sum;
   logic             sum_valid;
   logic [2:0]       state;

   modport master (
`ifdef SUBTRACT_EN
      output sub,
`endif
      output a_bus, b_bus, select, btn_load, clear,
      input  op_a, op_b, sum, sum_valid, state
   );

   modport slave (
`ifdef SUBTRACT_EN
      input  sub,
`endif
      input  a_bus, b_bus, select, btn_load, clear,
      output op_a, op_b, sum, sum_valid, state
   );
endinterface

// File: rtl/operand_latch_adder.sv
// Debounced two-operand capture with registered add (or subtract when SUBTRACT_EN is
// defined). Synchronous active-high reset; all outputs registered.
module operand_latch_adder #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned DB_CYCLES = 500000
) (
   input logic                  clk,
   input logic                  rst,
   operand_latch_adder_if.slave bus
);
   localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

   typedef enum logic [2:0] {
      StEmpty = 3'd0,
      StHaveA = 3'd1,
      StHaveB = 3'd2,
      StAdd   = 3'd3,
      StDone  = 3'd4
   } state_e;

   logic            sync1_q, sync2_q;
   logic            db_q, db_prev_q;
   logic [CntW-1:0] cnt_q;
   logic            load_pulse;

   state_e           state_q;
   logic [WIDTH-1:0] op_a_q, op_b_q;
   logic [WIDTH:0]   sum_q;
   logic             sum_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= bus.btn_load;
         sync2_q   <= sync1_q;
         db_prev_q <= db_q;
         // Level only flips after DB_CYCLES consecutive disagreeing samples.
         if (sync2_q != db_q) begin
            if (cnt_q == CntMax) begin
               db_q  <= ~db_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign load_pulse = db_q & ~db_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StEmpty;
         op_a_q      <= '0;
         op_b_q      <= '0;
         sum_q       <= '0;
         sum_valid_q <= 1'b0;
      end else if (bus.clear) begin
         state_q     <= StEmpty;
         op_a_q      <= '0;
         op_b_q      <= '0;
         sum_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (load_pulse) begin
                  if (bus.select) begin
                     op_a_q  <= bus.a_bus;
                     state_q <= StHaveA;
                  end else begin
                     op_b_q  <= bus.b_bus;
                     state_q <= StHaveB;
                  end
               end
            end
            StHaveA: begin
               if (load_pulse) begin
                  if (bus.select) begin
                     op_a_q <= bus.a_bus;
                  end else begin
                     op_b_q  <= bus.b_bus;
                     state_q <= StAdd;
                  end
               end
            end
            StHaveB: begin
               if (load_pulse) begin
                  if (bus.select) begin
                     op_a_q  <= bus.a_bus;
                     state_q <= StAdd;
                  end else begin
                     op_b_q <= bus.b_bus;
                  end
               end
            end
            StAdd: begin
`ifdef SUBTRACT_EN
               // Borrow lands in the MSB because both sides are zero-extended.
               if (bus.sub) sum_q <= {1'b0, op_a_q} - {1'b0, op_b_q};
               else         sum_q <= {1'b0, op_a_q} + {1'b0, op_b_q};
`else
               sum_q <= {1'b0, op_a_q} + {1'b0, op_b_q};
`endif
               sum_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               if (load_pulse) begin
                  if (bus.select) op_a_q <= bus.a_bus;
                  else            op_b_q <= bus.b_bus;
                  sum_valid_q <= 1'b0;
                  state_q     <= StAdd;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

   assign bus.op_a      = op_a_q;
   assign bus.op_b      = op_b_q;
   assign bus.sum       = sum_q;
   assign bus.sum_valid = sum_valid_q;
   assign bus.state     = state_q;
endmodule

// File: tb/tb_operand_latch_adder.sv
// Directed bench for operand_latch_adder with DB_CYCLES=4 (press-to-capture = 7 edges).
// Subtract vectors run only when SUBTRACT_EN is defined.
module tb_operand_latch_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   operand_latch_adder_if #(.WIDTH(4)) bus ();

   operand_latch_adder #(
      .WIDTH     (4),
      .DB_CYCLES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise the button and stop right after the capture edge.
   task automatic press(input logic sel, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] prev, input string tag);
      bus.select   = sel;
      bus.a_bus    = sel ? a : 4'h0;
      bus.b_bus    = sel ? 4'h0 : b;
      bus.btn_load = 1'b1;
      repeat (6) tick();
      check({tag, "_pre"}, 32'(bus.state), 32'(prev));
      tick();
   endtask

   task automatic release_btn();
      bus.btn_load = 1'b0;
      repeat (9) tick();
   endtask

   initial begin
      bus.a_bus    = '0;
      bus.b_bus    = '0;
      bus.select   = 1'b0;
      bus.btn_load = 1'b0;
      bus.clear    = 1'b0;
`ifdef SUBTRACT_EN
      bus.sub      = 1'b0;
`endif
      repeat (2) tick();
      rst = 1'b0;
      check("rst_op_a", 32'(bus.op_a), 32'h0);
      check("rst_op_b", 32'(bus.op_b), 32'h0);
      check("rst_sum", 32'(bus.sum), 32'h0);
      check("rst_valid", 32'(bus.sum_valid), 32'h0);
      check("rst_state", 32'(bus.state), 32'h0);

      // Basic add 9 + 5
      press(1'b1, 4'h9, 4'h0, 3'd0, "ld_a9");
      check("ld_a9_state", 32'(bus.state), 32'd1);
      check("ld_a9_op_a", 32'(bus.op_a), 32'h9);
      check("ld_a9_op_b", 32'(bus.op_b), 32'h0);
      release_btn();
      check("rel_a9_state", 32'(bus.state), 32'd1);
      press(1'b0, 4'h0, 4'h5, 3'd1, "ld_b5");
      check("ld_b5_state", 32'(bus.state), 32'd3);
      check("ld_b5_op_b", 32'(bus.op_b), 32'h5);
      check("ld_b5_valid", 32'(bus.sum_valid), 32'h0);
      tick();
      check("add_state", 32'(bus.state), 32'd4);
      check("add_sum", 32'(bus.sum), 32'h0E);
      check("add_valid", 32'(bus.sum_valid), 32'h1);
      release_btn();
      check("hold_sum", 32'(bus.sum), 32'h0E);
      check("hold_state", 32'(bus.state), 32'd4);

      // Carry and refresh from DONE
      press(1'b1, 4'hF, 4'h0, 3'd4, "ld_aF");
      check("ld_aF_state", 32'(bus.state), 32'd3);
      check("ld_aF_valid", 32'(bus.sum_valid), 32'h0);
      check("ld_aF_op_a", 32'(bus.op_a), 32'hF);
      tick();
      check("sum_F5", 32'(bus.sum), 32'h14);
      release_btn();
      press(1'b0, 4'h0, 4'h1, 3'd4, "ld_b1");
      tick();
      check("sum_F1", 32'(bus.sum), 32'h10);
      check("sum_F1_valid", 32'(bus.sum_valid), 32'h1);
      release_btn();
      press(1'b0, 4'h0, 4'hF, 3'd4, "ld_bF");
      check("ld_bF_valid", 32'(bus.sum_valid), 32'h0);
      tick();
      check("sum_FF", 32'(bus.sum), 32'h1E);
      check("sum_FF_valid", 32'(bus.sum_valid), 32'h1);
      check("sum_FF_state", 32'(bus.state), 32'd4);
      release_btn();

      // Clear keeps sum but drops everything else
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("clr_state", 32'(bus.state), 32'd0);
      check("clr_op_a", 32'(bus.op_a), 32'h0);
      check("clr_op_b", 32'(bus.op_b), 32'h0);
      check("clr_sum", 32'(bus.sum), 32'h1E);
      check("clr_valid", 32'(bus.sum_valid), 32'h0);

      // Clear colliding with a load pulse in HAVE_A
      press(1'b1, 4'h3, 4'h0, 3'd0, "ld_a3");
      check("ld_a3_state", 32'(bus.state), 32'd1);
      check("ld_a3_op_a", 32'(bus.op_a), 32'h3);
      release_btn();
      bus.a_bus    = 4'h7;
      bus.btn_load = 1'b1;
      repeat (6) tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("coll_state", 32'(bus.state), 32'd0);
      check("coll_op_a", 32'(bus.op_a), 32'h0);
      check("coll_op_b", 32'(bus.op_b), 32'h0);
      release_btn();
      check("coll_late_state", 32'(bus.state), 32'd0);

      // Bounce rejection, then one clean press
      bus.select = 1'b0;
      bus.a_bus  = 4'h0;
      bus.b_bus  = 4'h6;
      for (int i = 0; i < 20; i++) begin
         bus.btn_load = ((i / 2) % 2) == 0;
         tick();
      end
      check("bounce_state", 32'(bus.state), 32'd0);
      press(1'b0, 4'h0, 4'h6, 3'd0, "ld_b6");
      check("ld_b6_state", 32'(bus.state), 32'd2);
      check("ld_b6_op_b", 32'(bus.op_b), 32'h6);
      bus.b_bus = 4'h9;
      repeat (6) tick();
      for (int i = 0; i < 10; i++) begin
         bus.btn_load = (i % 2) == 0;
         tick();
      end
      release_btn();
      check("one_pulse_state", 32'(bus.state), 32'd2);
      check("one_pulse_op_b", 32'(bus.op_b), 32'h6);
      press(1'b1, 4'hA, 4'h0, 3'd2, "ld_aA");
      check("ld_aA_state", 32'(bus.state), 32'd3);
      tick();
      check("sum_A6", 32'(bus.sum), 32'h10);
      release_btn();

      // Reset mid-debounce discards partial count
      bus.select   = 1'b1;
      bus.a_bus    = 4'h5;
      bus.btn_load = 1'b1;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_state", 32'(bus.state), 32'd0);
      check("rst2_sum", 32'(bus.sum), 32'h0);
      repeat (6) tick();
      check("rst2_early", 32'(bus.state), 32'd0);
      tick();
      check("rst2_cap_state", 32'(bus.state), 32'd1);
      check("rst2_cap_op_a", 32'(bus.op_a), 32'h5);
      release_btn();

`ifdef SUBTRACT_EN
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      bus.sub   = 1'b1;
      press(1'b1, 4'h3, 4'h0, 3'd0, "sub_a3");
      release_btn();
      press(1'b0, 4'h0, 4'h5, 3'd1, "sub_b5");
      tick();
      check("sub_3m5", 32'(bus.sum), 32'h1E);
      release_btn();
      press(1'b1, 4'h7, 4'h0, 3'd4, "sub_a7");
      tick();
      check("sub_7m5", 32'(bus.sum), 32'h02);
      release_btn();
      press(1'b0, 4'h0, 4'h2, 3'd4, "sub_b2");
      tick();
      check("sub_7m2", 32'(bus.sum), 32'h05);
      release_btn();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
